fetch_unit: RTL

//  Instruction-fetch front end; producer side of the decode interface.

---
 rtl/riscv_pkg.sv | 24 ++
 rtl/fetch_fifo.sv | 74 +++++++
 rtl/fetch_unit.sv | 125 ++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 constants for the fetch and decode stages.
package riscv_pkg;

    localparam int unsigned XLEN      = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Width of an occupancy counter able to hold 0..depth.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush and occupancy count.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64,
    localparam int unsigned CW   = cnt_width(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CW-1:0]    count_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wptr_q] = wdata_i;
                wptr_d        = wptr_q + AW'(1);
            end
            if (do_pop) begin
                rptr_d = rptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues credit-limited word reads and
// buffers returned words with their PC toward decode over valid/ready.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN      = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(riscv_pkg::RESET_PC),
    parameter int unsigned     BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_plus4,
    input  logic            id_ready
);

    localparam int unsigned CW      = cnt_width(BUF_DEPTH);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(BUF_DEPTH);

    logic [XLEN-1:0]   pc_q, pc_d;
    logic [CW-1:0]     drop_q, drop_d;
    logic [CW-1:0]     occ, inflight;
    logic              buf_empty, buf_full, pcq_empty, pcq_full;
    logic [2*XLEN-1:0] buf_head;
    logic [XLEN-1:0]   rsp_pc;
    logic              id_take, req_fire, rsp_ok, buf_push, buf_pop;
    logic [CW:0]       committed, credit_lim;

    assign id_valid = !rst && !buf_empty;
    assign id_take  = id_valid && id_ready;

    // A slot freed by this cycle's decode pop may be re-issued at once; this is
    // what sustains one instruction per cycle with only BUF_DEPTH credits.
    assign committed      = {1'b0, occ} + {1'b0, inflight};
    assign credit_lim     = DEPTH_W + {{CW{1'b0}}, id_take};
    assign imem_req_valid = !rst && !redirect_valid && (committed < credit_lim);
    assign imem_req_addr  = pc_q;

    assign req_fire = imem_req_valid && imem_req_ready;
    assign rsp_ok   = imem_rsp_valid && !pcq_empty;
    assign buf_push = rsp_ok && (drop_q == '0) && !redirect_valid;
    assign buf_pop  = id_take && !redirect_valid;

    assign id_instr    = id_valid ? buf_head[2*XLEN-1:XLEN] : '0;
    assign id_pc       = id_valid ? buf_head[XLEN-1:0] : '0;
    assign id_pc_plus4 = id_valid ? buf_head[XLEN-1:0] + XLEN'(4) : '0;

    always_comb begin
        pc_d   = pc_q;
        drop_d = drop_q;
        if (redirect_valid) begin
            pc_d   = redirect_pc & ~XLEN'(3);
            // Every response still outstanding after this cycle belongs to the old path.
            drop_d = inflight - CW'(rsp_ok);
        end else begin
            if (req_fire) begin
                pc_d = pc_q + XLEN'(4);
            end
            if (rsp_ok && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= RESET_PC;
            drop_q <= '0;
        end else begin
            pc_q   <= pc_d;
            drop_q <= drop_d;
        end
    end

    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (2 * XLEN)
    ) u_ibuf (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (redirect_valid),
        .push_i  (buf_push),
        .wdata_i ({imem_rsp_data, rsp_pc}),
        .pop_i   (buf_pop),
        .rdata_o (buf_head),
        .count_o (occ),
        .empty_o (buf_empty),
        .full_o  (buf_full)
    );

    // PCs of accepted requests, popped in order as responses return.
    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (XLEN)
    ) u_pcq (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (1'b0),
        .push_i  (req_fire),
        .wdata_i (pc_q),
        .pop_i   (rsp_ok),
        .rdata_o (rsp_pc),
        .count_o (inflight),
        .empty_o (pcq_empty),
        .full_o  (pcq_full)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(imem_rsp_valid && buf_full));
            assert (!(imem_rsp_valid && pcq_empty));
            assert (!(req_fire && pcq_full));
        end
    end

endmodule
